// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LS memory port arbiter: FSM state and read-owner encodings.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: LS wins unless IF has been starved for the limit.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic starve_hit,
    output logic pick_if,
    output logic pick_ls
);

    // LS priority, overridden when the starvation limit is reached with IF waiting
    always_comb begin
        pick_ls = ls_req & ~(if_req & starve_hit);
        pick_if = if_req & ~pick_ls;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with one outstanding read, LS priority and an IF starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR       = 16,
    parameter int W_DATA     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [W_DATA-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [ADDR-1:0]   ls_addr,
    input  logic [W_DATA-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [W_DATA-1:0] ls_rdata,
    output logic              stall_o,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR-1:0]   mem_addr,
    output logic [W_DATA-1:0] mem_wdata,
    input  logic [W_DATA-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_M = CNT_W'(MAX_STARVE);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic pick_if_s, pick_ls_s, starve_hit_s, rd_done_s;

    assign starve_hit_s = (starve_cnt_q == STARVE_M);

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starve_hit (starve_hit_s),
        .pick_if    (pick_if_s),
        .pick_ls    (pick_ls_s)
    );

    // State register; an in-flight read is simply forgotten on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state: reads park in RD_WAIT for MEM_LAT cycles, stores stay in IDLE
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_gnt || (ls_gnt && !ls_write)) begin
                    state_d   = ARB_RD_WAIT;
                    owner_d   = ls_gnt ? OWN_LS : OWN_IF;
                    lat_cnt_d = LAT_M1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_RD_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = ARB_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Starvation counter only tracks LS grants that happen while IF is waiting
    always_comb begin
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (ls_gnt && !starve_hit_s) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Outputs: grants and mem strobe are combinational; everything is forced low in reset
    always_comb begin
        rd_done_s = (state_q == ARB_RD_WAIT) && (lat_cnt_q == 4'd0);
        if_gnt    = reset & (state_q == ARB_IDLE) & pick_if_s;
        ls_gnt    = reset & (state_q == ARB_IDLE) & pick_ls_s;
        mem_en    = if_gnt | ls_gnt;
        mem_we    = ls_gnt & ls_write;
        if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_wdata = '0;
        end else begin
            mem_addr  = '0;
            mem_wdata = '0;
        end
        if_rvalid = reset & rd_done_s & (owner_q == OWN_IF);
        ls_rvalid = reset & rd_done_s & (owner_q == OWN_LS);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
        stall_o   = reset & ((ls_req & ~ls_gnt) |
                             ((state_q == ARB_RD_WAIT) & (owner_q == OWN_LS) & ~ls_rvalid));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a cycle-numbered transaction model predicts grants, read returns and stall.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_write;
    logic [15:0] if_addr, ls_addr;
    logic [31:0] ls_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, stall_o, mem_en, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_wdata;
    logic [15:0] mem_addr;

    mem_port_arbiter #(.ADDR(16), .W_DATA(32), .MEM_LAT(LAT), .MAX_STARVE(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .stall_o(stall_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // memory macro (driven by DUT outputs) and reference memory (driven by the model)
    logic [31:0] mem_macro [64];
    logic [31:0] mem_ref   [64];
    bit          mac_valid = 1'b0;
    int          mac_ret   = 0;
    logic [31:0] mac_data  = 32'd0;

    // reference model state: pending read as (return cycle, owner, address)
    bit          m_pend = 1'b0;
    int          m_ret  = 0;
    bit          m_own_ls = 1'b0;
    logic [5:0]  m_addr = 6'd0;
    int          m_starve = 0;
    bit          e_if_gnt, e_ls_gnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_starve = 0;
    endtask

    task automatic tick(input logic ifr, input logic lsr, input logic lsw,
                        input logic [15:0] ifa, input logic [15:0] lsa, input logic [31:0] wd);
        bit          e_if_rv, e_ls_rv, e_stall;
        logic [31:0] e_data;
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = (mac_valid && cyc == mac_ret) ? mac_data : $urandom;
        if_req = ifr; ls_req = lsr; ls_write = lsw;
        if_addr = ifa; ls_addr = lsa; ls_wdata = wd;
        #3;
        e_if_gnt = 1'b0; e_ls_gnt = 1'b0; e_if_rv = 1'b0; e_ls_rv = 1'b0; e_data = 32'd0;
        if (m_pend) begin
            if (cyc == m_ret) begin
                e_data = mem_ref[m_addr];
                if (m_own_ls) e_ls_rv = 1'b1;
                else          e_if_rv = 1'b1;
            end
        end else if (lsr && !(ifr && m_starve == MAXS)) begin
            e_ls_gnt = 1'b1;
        end else if (ifr) begin
            e_if_gnt = 1'b1;
        end
        e_stall = (lsr && !e_ls_gnt) || (m_pend && m_own_ls && !e_ls_rv);

        check_eq("if_gnt",    {31'd0, if_gnt},    {31'd0, e_if_gnt});
        check_eq("ls_gnt",    {31'd0, ls_gnt},    {31'd0, e_ls_gnt});
        check_eq("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_if_rv});
        check_eq("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, e_ls_rv});
        check_eq("stall_o",   {31'd0, stall_o},   {31'd0, e_stall});
        check_eq("mem_en",    {31'd0, mem_en},    {31'd0, e_if_gnt | e_ls_gnt});
        check_eq("mem_we",    {31'd0, mem_we},    {31'd0, e_ls_gnt & lsw});
        if (e_ls_gnt) check_eq("mem_addr_ls", {16'd0, mem_addr}, {16'd0, lsa});
        if (e_if_gnt) check_eq("mem_addr_if", {16'd0, mem_addr}, {16'd0, ifa});
        if (e_ls_gnt && lsw) check_eq("mem_wdata", mem_wdata, wd);
        if (e_if_rv) check_eq("if_rdata", if_rdata, e_data);
        if (e_ls_rv) check_eq("ls_rdata", ls_rdata, e_data);

        if (m_pend && cyc == m_ret) m_pend = 1'b0;
        if (e_ls_gnt && lsw) begin
            mem_ref[lsa[5:0]] = wd;
        end else if (e_ls_gnt || e_if_gnt) begin
            m_pend   = 1'b1;
            m_ret    = cyc + LAT;
            m_own_ls = e_ls_gnt;
            m_addr   = e_ls_gnt ? lsa[5:0] : ifa[5:0];
        end
        if (e_if_gnt || !ifr) m_starve = 0;
        else if (e_ls_gnt && m_starve < MAXS) m_starve++;

        if (mac_valid && cyc == mac_ret) mac_valid = 1'b0;
        if (mem_en && mem_we) mem_macro[mem_addr[5:0]] = mem_wdata;
        else if (mem_en) begin
            mac_valid = 1'b1;
            mac_ret   = cyc + LAT;
            mac_data  = mem_macro[mem_addr[5:0]];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0);
    endtask

    initial begin
        bit          h_if, h_ls, h_w;
        logic [15:0] h_ifa, h_lsa;
        logic [31:0] h_wd;
        for (int i = 0; i < 64; i++) begin
            mem_macro[i] = $urandom;
            mem_ref[i]   = mem_macro[i];
        end
        mem_macro[16] = 32'hDEADBEEF;
        mem_ref[16]   = 32'hDEADBEEF;

        // reset state with both requests asserted: everything must stay quiet
        reset = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_write = 1'b1;
        if_addr = 16'h0003; ls_addr = 16'h0004; ls_wdata = 32'hA5A5A5A5; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_if_gnt",  {31'd0, if_gnt},  32'd0);
        check_eq("rst_ls_gnt",  {31'd0, ls_gnt},  32'd0);
        check_eq("rst_mem_en",  {31'd0, mem_en},  32'd0);
        check_eq("rst_mem_we",  {31'd0, mem_we},  32'd0);
        check_eq("rst_stall",   {31'd0, stall_o}, 32'd0);
        check_eq("rst_rvalid",  {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        check_eq("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        if_req = 1'b0; ls_req = 1'b0; ls_write = 1'b0;
        @(negedge clk) reset = 1'b1;
        model_reset();

        // reset in the middle of a load's wait: the load must never return
        tick(1'b0, 1'b1, 1'b0, 16'd0, 16'h0005, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0);
        #1 reset = 1'b0;
        #1;
        check_eq("midrd_stall",  {31'd0, stall_o},   32'd0);
        check_eq("midrd_rvalid", {31'd0, ls_rvalid}, 32'd0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        idle(4);

        // lone load of 0xDEADBEEF at address 0x0010
        tick(1'b0, 1'b1, 1'b0, 16'd0, 16'h0010, 32'd0);
        idle(3);

        // store then a fetch one cycle later, then read the stored word back
        tick(1'b0, 1'b1, 1'b1, 16'd0, 16'h0020, 32'h12345678);
        tick(1'b1, 1'b0, 1'b0, 16'h0007, 16'd0, 32'd0);
        idle(3);
        tick(1'b0, 1'b1, 1'b0, 16'd0, 16'h0020, 32'd0);
        idle(3);

        // simultaneous fetch and load: LS first, IF right after its rvalid
        tick(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0012, 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 16'h0011, 16'd0, 32'd0);
        idle(3);

        // both requesters saturating with loads: starvation guard interleaves IF
        for (int i = 0; i < 40; i++)
            tick(1'b1, 1'b1, 1'b0, 16'(i % 64), 16'((i * 7) % 64), 32'd0);
        idle(3);

        // random traffic with requests held until granted
        h_if = 1'b0; h_ls = 1'b0; h_w = 1'b0; h_ifa = 16'd0; h_lsa = 16'd0; h_wd = 32'd0;
        for (int i = 0; i < 10000; i++) begin
            if (!h_if) begin
                h_if  = ($urandom_range(0, 9) < 6);
                h_ifa = 16'($urandom_range(0, 63));
            end
            if (!h_ls) begin
                h_ls  = ($urandom_range(0, 9) < 6);
                h_w   = ($urandom_range(0, 2) == 0);
                h_lsa = 16'($urandom_range(0, 63));
                h_wd  = $urandom;
            end
            tick(h_if, h_ls, h_w, h_ifa, h_lsa, h_wd);
            if (e_if_gnt) h_if = 1'b0;
            if (e_ls_gnt) h_ls = 1'b0;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
